// File: rtl/input_conditioner.sv
// Gamepad input conditioner: synchronizes, debounces, and turns buttons into snake moves and control pulses.
// Latency: a clean level change reaches btn_state after DEBOUNCE_CYCLES+2 clocks; mov commits the cycle after a vsync fall.
// Backpressure: none; the block accepts every input cycle, and a newer direction request replaces an uncommitted one.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 252000,
   parameter int CNT_W           = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] btn_raw,
   input  logic       vsync,
   output logic [5:0] btn_state,
   output logic [3:0] mov,
   output logic       dir_changed,
   output logic       start_pulse,
   output logic       rst_snake_pulse
);

   // One-hot directions, same bit order as btn_raw[3:0]
   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   // Terminal count: the level is accepted on the cycle the counter sits here
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [5:0]            btn_meta_q, btn_sync_q;
   logic                  vs_meta_q, vs_sync_q, vs_dly_q;
   logic [5:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]            btn_state_q, btn_state_d;
   logic [5:0]            rise_c;
   logic [3:0]            mov_q, mov_d;
   logic [3:0]            pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;
   logic                  dir_changed_q, dir_changed_d;
   logic                  start_q, rst_snake_q;
   logic                  req_vld;
   logic [3:0]            req_dir;
   logic                  req_ok;
   logic                  frame_edge;

   // Swap up<->down and left<->right
   function automatic logic [3:0] opposite(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction

   // Two-flop synchronizers; vsync idles high so its flops reset to 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta_q <= '0;
         btn_sync_q <= '0;
         vs_meta_q  <= 1'b1;
         vs_sync_q  <= 1'b1;
         vs_dly_q   <= 1'b1;
      end else begin
         btn_meta_q <= btn_raw;
         btn_sync_q <= btn_meta_q;
         vs_meta_q  <= vsync;
         vs_sync_q  <= vs_meta_q;
         vs_dly_q   <= vs_sync_q;
      end
   end

   // Per-bit debounce: count while the input disagrees, accept at terminal count, clear on any agreement
   always_comb begin
      cnt_d       = cnt_q;
      btn_state_d = btn_state_q;
      rise_c      = '0;
      for (int i = 0; i < 6; i++) begin
         if (btn_sync_q[i] == btn_state_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]       = '0;
            btn_state_d[i] = btn_sync_q[i];
            rise_c[i]      = btn_sync_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Priority encode simultaneous direction rises: up, down, left, right
   always_comb begin
      req_vld = 1'b1;
      req_dir = DIR_RIGHT;
      if (rise_c[0])      req_dir = DIR_UP;
      else if (rise_c[1]) req_dir = DIR_DOWN;
      else if (rise_c[2]) req_dir = DIR_LEFT;
      else if (rise_c[3]) req_dir = DIR_RIGHT;
      else                req_vld = 1'b0;
   end

   assign req_ok     = req_vld && (req_dir != mov_q) && (req_dir != opposite(mov_q));
   assign frame_edge = vs_dly_q & ~vs_sync_q;

   // Move bookkeeping: snake reset wins, else commit pending at frame edge, and a new request lands in pending
   always_comb begin
      mov_d         = mov_q;
      pend_d        = pend_q;
      pend_vld_d    = pend_vld_q;
      dir_changed_d = 1'b0;
      if (rise_c[5]) begin
         mov_d      = DIR_RIGHT;
         pend_vld_d = 1'b0;
      end else begin
         if (frame_edge && pend_vld_q) begin
            mov_d         = pend_q;
            pend_vld_d    = 1'b0;
            dir_changed_d = 1'b1;
         end
         // A request arriving on the boundary cycle waits for the next frame
         if (req_ok) begin
            pend_d     = req_dir;
            pend_vld_d = 1'b1;
         end
      end
   end

   // State registers for debounce, moves and output pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         btn_state_q   <= '0;
         mov_q         <= DIR_RIGHT;
         pend_q        <= DIR_RIGHT;
         pend_vld_q    <= 1'b0;
         dir_changed_q <= 1'b0;
         start_q       <= 1'b0;
         rst_snake_q   <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         btn_state_q   <= btn_state_d;
         mov_q         <= mov_d;
         pend_q        <= pend_d;
         pend_vld_q    <= pend_vld_d;
         dir_changed_q <= dir_changed_d;
         start_q       <= rise_c[4];
         rst_snake_q   <= rise_c[5];
      end
   end

   assign btn_state       = btn_state_q;
   assign mov             = mov_q;
   assign dir_changed     = dir_changed_q;
   assign start_pulse     = start_q;
   assign rst_snake_pulse = rst_snake_q;

endmodule
